// File: rtl/uart_tlul_regs.sv
// TL-UL slave register front-end for the UART core.
// Decodes Get/Put transactions into control registers, TX/RX FIFO pulses
// and status read-back. One transaction in flight; response held in RESP.
//
// Handshake: a transfer on either channel happens on a rising clock edge
// where valid and ready are both high; a valid source holds its payload
// stable until that edge, and ready may not depend on the same channel's valid.
module uart_tlul_regs #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          SRC_WIDTH  = 8,
  parameter logic [23:0] BAUD_RESET = 24'd27
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_valid,
  output logic                  o_a_ready,
  input  logic [2:0]            i_a_opcode,
  input  logic [1:0]            i_a_size,
  input  logic [SRC_WIDTH-1:0]  i_a_source,
  input  logic [ADDR_WIDTH-1:0] i_a_address,
  input  logic [3:0]            i_a_mask,
  input  logic [31:0]           i_a_data,
  output logic                  o_d_valid,
  input  logic                  i_d_ready,
  output logic [2:0]            o_d_opcode,
  output logic [1:0]            o_d_size,
  output logic [SRC_WIDTH-1:0]  o_d_source,
  output logic [31:0]           o_d_data,
  output logic                  o_d_error,
  output logic                  o_rx_en,
  output logic                  o_tx_en,
  output logic [1:0]            o_width_sel,
  output logic [2:0]            o_parity_sel,
  output logic                  o_stop_sel,
  output logic [23:0]           o_baud_rate_value,
  output logic                  o_store_uart,
  output logic [7:0]            o_trans_data,
  output logic                  o_load_uart,
  input  logic                  i_tx_fifo_full,
  input  logic                  i_rx_data_avail,
  input  logic                  i_e_overrun_flag,
  input  logic                  i_e_parity_flag,
  input  logic                  i_e_frame_flag,
  input  logic [7:0]            i_receive_data,
  output logic                  o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] ACK            = 3'd0;
  localparam logic [2:0] ACK_DATA       = 3'd1;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_BAUD   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_TXDATA = 3'd3;
  localparam logic [2:0] REG_RXDATA = 3'd4;

  state_t      state;
  logic [7:0]  ctrl;
  logic [23:0] baud;
  logic        accept;
  logic        is_get;
  logic        is_put;
  logic [2:0]  offset;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        do_store;
  logic        do_load;
  logic        unused_bits;

  // Address bits outside [4:2] and data bits above the widest register are don't-care.
  assign unused_bits = ^{i_a_address, i_a_data[31:24]};

  assign offset    = i_a_address[4:2];
  assign is_get    = (i_a_opcode == OP_GET);
  assign is_put    = (i_a_opcode == OP_PUT_FULL) || (i_a_opcode == OP_PUT_PARTIAL);
  assign o_a_ready = (state == IDLE) && !i_rst;
  assign o_d_valid = (state == RESP);
  assign accept    = i_a_valid && o_a_ready;
  assign o_dbg_state = state;

  assign o_rx_en           = ctrl[0];
  assign o_tx_en           = ctrl[1];
  assign o_width_sel       = ctrl[3:2];
  assign o_parity_sel      = ctrl[6:4];
  assign o_stop_sel        = ctrl[7];
  assign o_baud_rate_value = baud;

  // Decode the request on the A channel into response data, error and side-effect requests.
  always_comb begin
    rd_data  = '0;
    rd_err   = 1'b0;
    do_store = 1'b0;
    do_load  = 1'b0;
    if (is_get) begin
      case (offset)
        REG_CTRL:   rd_data = {24'd0, ctrl};
        REG_BAUD:   rd_data = {8'd0, baud};
        REG_STATUS: rd_data = {27'd0, i_e_frame_flag, i_e_parity_flag, i_e_overrun_flag,
                               i_rx_data_avail, i_tx_fifo_full};
        REG_RXDATA: begin
          if (i_rx_data_avail) begin
            rd_data = {22'd0, i_e_frame_flag, i_e_parity_flag, i_receive_data};
            do_load = 1'b1;
          end
        end
        default:    rd_err = 1'b1;
      endcase
    end else if (is_put) begin
      case (offset)
        REG_CTRL, REG_BAUD: rd_err = 1'b0;
        REG_TXDATA: begin
          if (i_a_mask[0] && !i_tx_fifo_full) do_store = 1'b1;
          else                                 rd_err   = 1'b1;
        end
        // STATUS and RXDATA are read-only; everything else is unmapped.
        default:    rd_err = 1'b1;
      endcase
    end else begin
      rd_err = 1'b1;
    end
  end

  // Transaction FSM: capture the response on acceptance, hold it until the D handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_d_opcode   <= ACK;
      o_d_size     <= '0;
      o_d_source   <= '0;
      o_d_data     <= '0;
      o_d_error    <= 1'b0;
      o_store_uart <= 1'b0;
      o_load_uart  <= 1'b0;
      o_trans_data <= '0;
    end else begin
      o_store_uart <= 1'b0;
      o_load_uart  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= RESP;
            o_d_opcode   <= is_get ? ACK_DATA : ACK;
            o_d_size     <= i_a_size;
            o_d_source   <= i_a_source;
            o_d_data     <= rd_data;
            o_d_error    <= rd_err;
            o_store_uart <= do_store;
            o_load_uart  <= do_load;
            if (do_store) o_trans_data <= i_a_data[7:0];
          end
        end
        RESP: begin
          if (i_d_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane masked writes to CTRL and BAUD, visible the cycle after acceptance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl <= '0;
      baud <= BAUD_RESET;
    end else if (accept && is_put) begin
      if (offset == REG_CTRL && i_a_mask[0]) ctrl <= i_a_data[7:0];
      if (offset == REG_BAUD) begin
        for (int i = 0; i < 3; i++) begin
          if (i_a_mask[i]) baud[8*i +: 8] <= i_a_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tlul_regs.sv
// Testbench for uart_tlul_regs: directed vector table, backpressure and
// mid-transaction reset sequences, then random traffic against a register model.
module tb_uart_tlul_regs;

  localparam int AW = 8;
  localparam int SW = 8;
  localparam logic [23:0] BAUD_RST = 24'd27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, d_valid, d_ready, d_error;
  logic [2:0]    a_opcode, d_opcode;
  logic [1:0]    a_size, d_size;
  logic [SW-1:0] a_source, d_source;
  logic [AW-1:0] a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data, d_data;
  logic          rx_en, tx_en, stop_sel, store, load, dbg_state;
  logic [1:0]    width_sel;
  logic [2:0]    parity_sel;
  logic [23:0]   baud;
  logic [7:0]    trans_data, rx_data;
  logic          tx_full, rx_avail, overrun, par_err, frm_err;

  uart_tlul_regs #(.ADDR_WIDTH(AW), .SRC_WIDTH(SW), .BAUD_RESET(BAUD_RST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_opcode(a_opcode), .i_a_size(a_size),
    .i_a_source(a_source), .i_a_address(a_address), .i_a_mask(a_mask), .i_a_data(a_data),
    .o_d_valid(d_valid), .i_d_ready(d_ready), .o_d_opcode(d_opcode), .o_d_size(d_size),
    .o_d_source(d_source), .o_d_data(d_data), .o_d_error(d_error),
    .o_rx_en(rx_en), .o_tx_en(tx_en), .o_width_sel(width_sel), .o_parity_sel(parity_sel),
    .o_stop_sel(stop_sel), .o_baud_rate_value(baud), .o_store_uart(store),
    .o_trans_data(trans_data), .o_load_uart(load),
    .i_tx_fifo_full(tx_full), .i_rx_data_avail(rx_avail), .i_e_overrun_flag(overrun),
    .i_e_parity_flag(par_err), .i_e_frame_flag(frm_err), .i_receive_data(rx_data),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];   // {d_opcode, d_error, d_data}

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_ctrl = 8'h00;
  logic [23:0] m_baud = BAUD_RST;

  // Register-map view: compute response and side effects from the current model.
  task automatic predict(input logic [2:0] op, input logic [7:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output logic e_store, output logic e_load,
                         output logic [7:0] e_trans);
    int          off;
    logic [2:0]  opc;
    logic        err;
    logic [31:0] rd;
    off = (int'(addr) / 4) % 8;
    opc = (op == 3'd4) ? 3'd1 : 3'd0;
    err = 1'b0; rd = 32'd0; e_store = 1'b0; e_load = 1'b0; e_trans = 8'd0;
    if (op == 3'd4) begin
      case (off)
        0: rd = 32'(m_ctrl);
        1: rd = 32'(m_baud);
        2: rd = 32'(tx_full) + 2 * 32'(rx_avail) + 4 * 32'(overrun) + 8 * 32'(par_err) + 16 * 32'(frm_err);
        4: if (rx_avail) begin
             rd = 32'(rx_data) + 256 * 32'(par_err) + 512 * 32'(frm_err);
             e_load = 1'b1;
           end
        default: err = 1'b1;
      endcase
    end else if (op == 3'd0 || op == 3'd1) begin
      case (off)
        0: if (mask[0]) m_ctrl = data[7:0];
        1: for (int i = 0; i < 3; i++) if (mask[i]) m_baud[8*i +: 8] = data[8*i +: 8];
        3: if (mask[0] && !tx_full) begin e_store = 1'b1; e_trans = data[7:0]; end
           else err = 1'b1;
        default: err = 1'b1;
      endcase
    end else begin
      err = 1'b1;
    end
    exp_q.push_back({opc, err, rd});
  endtask

  // ---------------- driver ----------------
  logic [2:0]  last_opc;
  logic        last_err, last_store, last_load;
  logic [31:0] last_data;
  logic [7:0]  last_trans;

  task automatic check_cfg(input string name);
    chk(name, {stop_sel, parity_sel, width_sel, tx_en, rx_en}, m_ctrl);
    chk(name, baud, m_baud);
  endtask

  // One complete transaction with d_ready held high; checks against the model.
  task automatic run_txn(input logic [2:0] op, input logic [7:0] addr, input logic [3:0] mask,
                         input logic [31:0] data);
    logic        e_store, e_load;
    logic [7:0]  e_trans;
    logic [35:0] exp;
    logic [SW-1:0] src;
    logic [1:0]  sz;
    int          n;
    src = SW'($urandom);
    sz  = 2'($urandom);
    @(negedge clk);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_size = sz; d_ready = 1'b1;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    if (!a_ready) begin
      chk("accept_timeout", 36'd0, 36'd1);
      a_valid = 1'b0;
      return;
    end
    predict(op, addr, mask, data, e_store, e_load, e_trans);
    @(posedge clk); #1;
    a_valid = 1'b0;
    last_store = store; last_load = load; last_trans = trans_data;
    last_opc = d_opcode; last_err = d_error; last_data = d_data;
    chk("store_pulse", store, e_store);
    chk("load_pulse", load, e_load);
    if (e_store) chk("trans_data", trans_data, e_trans);
    chk("d_valid_resp", d_valid, 1'b1);
    chk("state_resp", dbg_state, 1'b1);
    chk("a_ready_resp", a_ready, 1'b0);
    exp = exp_q.pop_front();
    chk("d_resp", {d_opcode, d_error, d_data}, exp);
    chk("d_echo", {d_source, d_size}, {src, sz});
    check_cfg("cfg");
    @(posedge clk); #1;
    chk("pulse_clear", {store, load}, 2'b00);
    chk("d_valid_done", d_valid, 1'b0);
    chk("a_ready_idle", a_ready, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [4:0]  stat;     // {frame, parity, overrun, rx_avail, tx_full}
    logic [7:0]  rxd;
    logic [2:0]  e_opc;
    logic        e_err;
    logic [31:0] e_data;
    logic        e_store;
    logic        e_load;
    logic [7:0]  e_ctrl;
    logic [23:0] e_baud;
  } vec_t;

  vec_t vecs [0:20];

  initial begin
    logic [35:0] snap;
    logic        e_s, e_l;
    logic [7:0]  e_t;
    logic [35:0] exp;

    vecs[0]  = '{3'd4, 8'h04, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'h1B,     1'b0, 1'b0, 8'h00, 24'h00001B};
    vecs[1]  = '{3'd4, 8'h00, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'h0,      1'b0, 1'b0, 8'h00, 24'h00001B};
    vecs[2]  = '{3'd1, 8'h00, 4'h1, 32'hB3,       5'h00, 8'h00, 3'd0, 1'b0, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h00001B};
    vecs[3]  = '{3'd4, 8'h00, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'hB3,     1'b0, 1'b0, 8'hB3, 24'h00001B};
    vecs[4]  = '{3'd0, 8'h04, 4'hF, 32'h0,        5'h00, 8'h00, 3'd0, 1'b0, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h000000};
    vecs[5]  = '{3'd0, 8'h04, 4'h6, 32'h12345678, 5'h00, 8'h00, 3'd0, 1'b0, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[6]  = '{3'd4, 8'h04, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'h345600, 1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[7]  = '{3'd4, 8'h07, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'h345600, 1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[8]  = '{3'd4, 8'h20, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b0, 32'hB3,     1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[9]  = '{3'd0, 8'h0C, 4'hF, 32'hA5,       5'h00, 8'h00, 3'd0, 1'b0, 32'h0,      1'b1, 1'b0, 8'hB3, 24'h345600};
    vecs[10] = '{3'd0, 8'h0C, 4'hF, 32'hA5,       5'h01, 8'h00, 3'd0, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[11] = '{3'd0, 8'h0C, 4'hE, 32'h5A,       5'h00, 8'h00, 3'd0, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[12] = '{3'd4, 8'h10, 4'hF, 32'h0,        5'h0A, 8'h3C, 3'd1, 1'b0, 32'h13C,    1'b0, 1'b1, 8'hB3, 24'h345600};
    vecs[13] = '{3'd4, 8'h10, 4'hF, 32'h0,        5'h00, 8'h3C, 3'd1, 1'b0, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[14] = '{3'd4, 8'h1C, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[15] = '{3'd3, 8'h00, 4'hF, 32'hFFFFFFFF, 5'h00, 8'h00, 3'd0, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[16] = '{3'd5, 8'h04, 4'hF, 32'h0,        5'h00, 8'h00, 3'd0, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[17] = '{3'd4, 8'h0C, 4'hF, 32'h0,        5'h00, 8'h00, 3'd1, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[18] = '{3'd0, 8'h10, 4'hF, 32'h1,        5'h02, 8'h77, 3'd0, 1'b1, 32'h0,      1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[19] = '{3'd4, 8'h08, 4'hF, 32'h0,        5'h15, 8'h00, 3'd1, 1'b0, 32'h15,     1'b0, 1'b0, 8'hB3, 24'h345600};
    vecs[20] = '{3'd4, 8'h08, 4'hF, 32'h0,        5'h0A, 8'h00, 3'd1, 1'b0, 32'h0A,     1'b0, 1'b0, 8'hB3, 24'h345600};

    a_valid = 1'b0; a_opcode = 3'd4; a_size = 2'd2; a_source = '0; a_address = '0;
    a_mask = 4'hF; a_data = '0; d_ready = 1'b1;
    {frm_err, par_err, overrun, rx_avail, tx_full} = 5'h00; rx_data = 8'h00;

    // ---- reset values ----
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_d_data_err", {d_error, d_data}, 33'd0);
    chk("rst_pulses", {store, load}, 2'b00);
    check_cfg("rst_cfg");
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_release_a_ready", a_ready, 1'b1);

    // ---- table vectors ----
    for (int i = 0; i < 21; i++) begin
      {frm_err, par_err, overrun, rx_avail, tx_full} = vecs[i].stat;
      rx_data = vecs[i].rxd;
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data);
      chk($sformatf("vec%0d_resp", i), {last_opc, last_err, last_data},
          {vecs[i].e_opc, vecs[i].e_err, vecs[i].e_data});
      chk($sformatf("vec%0d_pulses", i), {last_store, last_load}, {vecs[i].e_store, vecs[i].e_load});
      if (vecs[i].e_store) chk($sformatf("vec%0d_trans", i), last_trans, vecs[i].data[7:0]);
      chk($sformatf("vec%0d_ctrl", i), {stop_sel, parity_sel, width_sel, tx_en, rx_en}, vecs[i].e_ctrl);
      chk($sformatf("vec%0d_baud", i), baud, vecs[i].e_baud);
    end
    {frm_err, par_err, overrun, rx_avail, tx_full} = 5'h00;

    // ---- backpressure: response held, second request waits ----
    @(negedge clk);
    d_ready = 1'b0; a_valid = 1'b1; a_opcode = 3'd4; a_address = 8'h00; a_source = 8'h11;
    a_size = 2'd2;
    predict(3'd4, 8'h00, 4'hF, 32'h0, e_s, e_l, e_t);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    chk("bp_first_resp", {d_opcode, d_error, d_data}, exp);
    snap = {d_opcode, d_error, d_data[23:0], d_source, d_size};
    a_address = 8'h04; a_source = 8'h22; a_size = 2'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_d_valid", d_valid, 1'b1);
      chk("bp_a_ready", a_ready, 1'b0);
      chk("bp_stable", {d_opcode, d_error, d_data[23:0], d_source, d_size}, snap);
    end
    @(negedge clk) d_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_idle", {d_valid, a_ready}, 2'b01);
    predict(3'd4, 8'h04, 4'hF, 32'h0, e_s, e_l, e_t);
    @(posedge clk); #1;
    a_valid = 1'b0;
    exp = exp_q.pop_front();
    chk("bp_second_resp", {d_opcode, d_error, d_data}, exp);
    chk("bp_second_echo", {d_source, d_size}, {8'h22, 2'd1});
    @(posedge clk); #1;
    chk("bp_second_done", d_valid, 1'b0);

    // ---- reset while a response is pending ----
    run_txn(3'd0, 8'h00, 4'h1, 32'h000000FF);
    run_txn(3'd0, 8'h04, 4'hF, 32'h00ABCDEF);
    @(negedge clk);
    d_ready = 1'b0; a_valid = 1'b1; a_opcode = 3'd4; a_address = 8'h10;
    rx_avail = 1'b1; rx_data = 8'h55;
    predict(3'd4, 8'h10, 4'hF, 32'h0, e_s, e_l, e_t);
    @(posedge clk); #1;
    a_valid = 1'b0; rx_avail = 1'b0;
    exp = exp_q.pop_front();
    chk("mid_resp", {d_opcode, d_error, d_data}, exp);
    chk("mid_load", load, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    m_ctrl = 8'h00; m_baud = BAUD_RST;
    #1;
    chk("mid_rst_d_valid", d_valid, 1'b0);
    chk("mid_rst_a_ready", a_ready, 1'b0);
    chk("mid_rst_d_data_err", {d_error, d_data}, 33'd0);
    chk("mid_rst_pulses", {store, load}, 2'b00);
    check_cfg("mid_rst_cfg");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    d_ready = 1'b1;
    #1 chk("mid_rst_release", {a_ready, d_valid}, 2'b10);
    run_txn(3'd4, 8'h04, 4'hF, 32'h0);

    // ---- random traffic against the model ----
    for (int t = 0; t < 200; t++) begin
      logic [2:0]  op;
      logic [7:0]  addr;
      int          r;
      r = $urandom_range(0, 7);
      op = (r < 3) ? 3'd4 : (r == 3) ? 3'd0 : (r == 4) ? 3'd1 : 3'($urandom);
      addr = {3'($urandom), 3'($urandom_range(0, 5)), 2'($urandom)};
      {frm_err, par_err, overrun, rx_avail, tx_full} = 5'($urandom);
      rx_data = 8'($urandom);
      run_txn(op, addr, 4'($urandom), $urandom);
    end

    chk("scoreboard_drained", 36'(exp_q.size()), 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
